mips_seq_alu: RTL and testbench

//  Execution-side consumer of the 4-bit ALUoperation code from the ALU control decoder.

---
 rtl/mips_seq_alu.sv | 244 ++++++++++++++++++++++++
 tb/tb_mips_seq_alu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_seq_alu.sv
// -----------------------------------------------------------------------------
// mips_seq_alu
//   Execution-side ALU driven by the 4-bit ALUoperation code from the ALU
//   control decoder. Logic ops and add/sub/slt finish in one cycle. Shifts move
//   one bit per cycle and multiply is shift-add over WIDTH cycles. A
//   start/busy/done handshake lets the datapath stall on multi-cycle ops.
//
//   Optional feature macro: ALU_MUL_EN
//     defined   -> MUL (1010) is iterative, and the hi output carries the
//                  upper half of the product.
//     undefined -> no multiplier logic and no hi port; 1010 is illegal.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request, taken when idle or in the done cycle
//   ALUoperation  op code
//   A, B          operands (rs, rt/imm)
//   shamt         shift amount for SLL/SRL
//   busy          op in progress (falls together with done)
//   done          one-cycle pulse, result/flags valid
//   result        registered result, held until the next done
//   zero          result == 0
//   ovf           signed overflow, add/sub only
//   illegal       unsupported op code
//   hi            upper product half (ALU_MUL_EN only)
// -----------------------------------------------------------------------------
module mips_seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         ALUoperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
`ifdef ALU_MUL_EN
    ,
    output logic [WIDTH-1:0]   hi
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;

    // Counter must hold both the largest shift amount and the WIDTH mul steps.
    localparam int CNT_W = ($clog2(WIDTH + 1) > SHAMT_W) ? $clog2(WIDTH + 1) : SHAMT_W;

    // EXEC is the done cycle for every op; multi-cycle ops land there after
    // their final iteration.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_MUL   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   work_reg;
    logic               right_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg, ovf_reg, illegal_reg;

    logic               accept;
    logic               is_shift, is_mul, last_step;
    state_t             entry_state;
    logic [WIDTH-1:0]   shifted;

    // Single-cycle datapath
    logic               sub_sel;
    logic [WIDTH-1:0]   b_eff, sum;
    logic [WIDTH-1:0]   fast_res;
    logic               fast_ovf, fast_ill;

    assign accept    = start && (state_reg == S_IDLE || state_reg == S_EXEC);
    assign is_shift  = (ALUoperation == OP_SLL) || (ALUoperation == OP_SRL);
`ifdef ALU_MUL_EN
    assign is_mul    = (ALUoperation == OP_MUL);
`else
    assign is_mul    = 1'b0;
`endif
    assign last_step = (cnt_reg == CNT_W'(1));
    assign shifted   = right_reg ? (work_reg >> 1) : (work_reg << 1);

    always_comb begin
        entry_state = S_EXEC;
        if (is_shift && shamt != '0)
            entry_state = S_SHIFT;
        else if (is_mul)
            entry_state = S_MUL;
    end

    // Add and subtract share one adder; SUB feeds ~B with a carry-in of 1.
    assign sub_sel = (ALUoperation == OP_SUB);
    assign b_eff   = sub_sel ? ~B : B;
    assign sum     = A + b_eff + {{(WIDTH-1){1'b0}}, sub_sel};

    always_comb begin
        fast_res = '0;
        fast_ovf = 1'b0;
        fast_ill = 1'b0;
        case (ALUoperation)
            OP_AND: fast_res = A & B;
            OP_OR:  fast_res = A | B;
            OP_NOR: fast_res = ~(A | B);
            OP_ADD, OP_SUB: begin
                fast_res = sum;
                fast_ovf = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            // Direct signed compare, so an overflowing A-B cannot flip it.
            OP_SLT: fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            // Only reached with shamt == 0: the result is A unchanged.
            OP_SLL, OP_SRL: fast_res = A;
`ifdef ALU_MUL_EN
            OP_MUL: fast_res = '0;   // handled by the iterative path
`endif
            default: fast_ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add multiplier: acc holds the upper product half, work_reg the
    // multiplier shifting out on the right while product bits enter on the left.
    logic [WIDTH-1:0] acc_reg, mcand_reg, hi_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_step, low_step;

    assign mul_sum  = {1'b0, acc_reg} + (work_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_step = mul_sum[WIDTH:1];
    assign low_step = {mul_sum[0], work_reg[WIDTH-1:1]};
    assign hi       = hi_reg;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = entry_state;
            S_EXEC:  state_next = accept ? entry_state : S_IDLE;
            S_SHIFT: if (last_step) state_next = S_EXEC;
`ifdef ALU_MUL_EN
            S_MUL:   if (last_step) state_next = S_EXEC;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            work_reg    <= '0;
            right_reg   <= 1'b0;
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef ALU_MUL_EN
            acc_reg     <= '0;
            mcand_reg   <= '0;
            hi_reg      <= '0;
`endif
        end else if (accept) begin
            if (entry_state == S_SHIFT) begin
                work_reg  <= A;
                right_reg <= ALUoperation[0];
                cnt_reg   <= CNT_W'(shamt);
`ifdef ALU_MUL_EN
            end else if (entry_state == S_MUL) begin
                work_reg  <= B;
                mcand_reg <= A;
                acc_reg   <= '0;
                cnt_reg   <= CNT_W'(WIDTH);
`endif
            end else begin
                result_reg  <= fast_res;
                zero_reg    <= (fast_res == '0);
                ovf_reg     <= fast_ovf;
                illegal_reg <= fast_ill;
`ifdef ALU_MUL_EN
                hi_reg      <= '0;
`endif
            end
        end else if (state_reg == S_SHIFT) begin
            if (last_step) begin
                result_reg  <= shifted;
                zero_reg    <= (shifted == '0);
                ovf_reg     <= 1'b0;
                illegal_reg <= 1'b0;
`ifdef ALU_MUL_EN
                hi_reg      <= '0;
`endif
            end else begin
                work_reg <= shifted;
                cnt_reg  <= cnt_reg - CNT_W'(1);
            end
`ifdef ALU_MUL_EN
        end else if (state_reg == S_MUL) begin
            if (last_step) begin
                result_reg  <= low_step;
                hi_reg      <= acc_step;
                zero_reg    <= (low_step == '0);
                ovf_reg     <= 1'b0;
                illegal_reg <= 1'b0;
            end else begin
                acc_reg  <= acc_step;
                work_reg <= low_step;
                cnt_reg  <= cnt_reg - CNT_W'(1);
            end
`endif
        end
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_EXEC);
    assign result  = result_reg;
    assign zero    = zero_reg;
    assign ovf     = ovf_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_mips_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_mips_seq_alu
//   Directed bench for mips_seq_alu (WIDTH=32, SHAMT_W=5). A behavioural model
//   predicts result/flags/latency for every issued op; one compare process
//   checks busy and done every cycle and the result fields on each done.
//   Hand-computed literals pin the model on the key vectors.
// -----------------------------------------------------------------------------
module tb_mips_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ALUoperation = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        busy, done, zero, ovf, illegal;
    logic [31:0] result;
`ifdef ALU_MUL_EN
    logic [31:0] hi;
`endif

    mips_seq_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUoperation(ALUoperation),
        .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
        .result(result), .zero(zero), .ovf(ovf), .illegal(illegal)
`ifdef ALU_MUL_EN
        , .hi(hi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          done_cyc;
        int          lat;
        logic [31:0] res;
        logic [31:0] hi;
        logic        ovf;
        logic        ill;
        logic        zero;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          issue_cyc = 0;
    int          last_done_cyc = 0;
    logic [31:0] last_res;
    logic        last_zero, last_ovf, last_ill;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Model: result/flags/latency straight from the op-code rules.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   m;
        longint sa, sb, s;
        logic [63:0] p;
        m.done_cyc = 0; m.lat = 1; m.res = 0; m.hi = 0; m.ovf = 0; m.ill = 0; m.zero = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            4'b0000: m.res = a & b;
            4'b0001: m.res = a | b;
            4'b1100: m.res = ~(a | b);
            4'b0010: begin s = sa + sb; m.res = s[31:0];
                     m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sa - sb; m.res = s[31:0];
                     m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0111: m.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: begin m.res = a << sh; m.lat = int'(sh) + 1; end
            4'b1001: begin m.res = a >> sh; m.lat = int'(sh) + 1; end
`ifdef ALU_MUL_EN
            4'b1010: begin p = {32'd0, a} * {32'd0, b}; m.res = p[31:0];
                     m.hi = p[63:32]; m.lat = 33; end
`endif
            default: m.ill = 1'b1;
        endcase
        m.zero = (m.res == 32'd0);
        return m;
    endfunction

    // Compare process
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_busy, exp_done;
            exp_busy = (q.size() != 0);
            exp_done = exp_busy && (cyc == q[0].done_cyc);
            check("busy", {63'd0, busy}, {63'd0, exp_busy});
            check("done", {63'd0, done}, {63'd0, exp_done});
            if (exp_done) begin
                check("result",  {32'd0, result}, {32'd0, q[0].res});
                check("zero",    {63'd0, zero},    {63'd0, q[0].zero});
                check("ovf",     {63'd0, ovf},     {63'd0, q[0].ovf});
                check("illegal", {63'd0, illegal}, {63'd0, q[0].ill});
`ifdef ALU_MUL_EN
                check("hi",      {32'd0, hi},      {32'd0, q[0].hi});
`endif
                last_res = result; last_zero = zero; last_ovf = ovf; last_ill = illegal;
                last_done_cyc = cyc;
                void'(q.pop_front());
            end else if (exp_busy && cyc > q[0].done_cyc) begin
                void'(q.pop_front());
            end
        end
    end

    task automatic sync();
        @(negedge clk); #2;
    endtask

    // Drive an op for one edge, then scramble the inputs while it runs.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        exp_t m;
        m = model(op, a, b, sh);
        m.done_cyc = cyc + m.lat;
        issue_cyc = cyc;
        q.push_back(m);
        ALUoperation = op; A = a; B = b; shamt = sh; start = 1'b1;
        sync();
        start = 1'b0;
        A = $urandom; B = $urandom; ALUoperation = 4'($urandom); shamt = 5'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin sync(); n++; end
        if (q.size() != 0) begin
            check("timeout", 64'd1, 64'd0);
            q.delete();
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] res, input logic z,
                             input logic o, input logic il, input int lat);
        check({name, "_res"}, {32'd0, last_res}, {32'd0, res});
        check({name, "_zero"}, {63'd0, last_zero}, {63'd0, z});
        check({name, "_ovf"}, {63'd0, last_ovf}, {63'd0, o});
        check({name, "_ill"}, {63'd0, last_ill}, {63'd0, il});
        check({name, "_lat"}, 64'(last_done_cyc - issue_cyc), 64'(lat));
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
        check({name, "_result"}, {32'd0, result}, 64'd0);
        check({name, "_zero"}, {63'd0, zero}, 64'd0);
        check({name, "_ovf"}, {63'd0, ovf}, 64'd0);
        check({name, "_illegal"}, {63'd0, illegal}, 64'd0);
`ifdef ALU_MUL_EN
        check({name, "_hi"}, {32'd0, hi}, 64'd0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        sync();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        sync();

        issue(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0); wait_idle();
        $display("ADD 7FFFFFFF+1 -> %h ovf=%b", last_res, last_ovf);
        check_lit("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0, 1);

        issue(4'b0110, 32'h5, 32'h5, 5'd0); wait_idle();
        $display("SUB 5-5 -> %h zero=%b", last_res, last_zero);
        check_lit("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0, 1);

        issue(4'b0111, 32'h80000000, 32'h1, 5'd0); wait_idle();
        $display("SLT 80000000<1 -> %h", last_res);
        check_lit("slt_neg", 32'h1, 1'b0, 1'b0, 1'b0, 1);

        issue(4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0); wait_idle();
        $display("SLT 7FFFFFFF<80000000 -> %h", last_res);
        check_lit("slt_ovf", 32'h0, 1'b1, 1'b0, 1'b0, 1);

        issue(4'b1100, 32'h0, 32'h0, 5'd0); wait_idle();
        $display("NOR 0,0 -> %h", last_res);
        check_lit("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);

        issue(4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0); wait_idle();
        $display("AND -> %h", last_res);
        check_lit("and", 32'h0F000F00, 1'b0, 1'b0, 1'b0, 1);

        issue(4'b0001, 32'hF0000000, 32'h0000000F, 5'd0); wait_idle();
        $display("OR -> %h", last_res);

        issue(4'b0110, 32'h80000000, 32'h1, 5'd0); wait_idle();
        $display("SUB 80000000-1 -> %h ovf=%b", last_res, last_ovf);
        check_lit("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1);

        // SLL by 31 with start pokes while busy; they must be ignored.
        issue(4'b1000, 32'h1, 32'h0, 5'd31);
        repeat (3) sync();
        ALUoperation = 4'b0010; A = 32'h1; B = 32'h2; start = 1'b1;
        repeat (2) sync();
        start = 1'b0;
        wait_idle();
        $display("SLL 1<<31 -> %h lat=%0d", last_res, last_done_cyc - issue_cyc);
        check_lit("sll31", 32'h80000000, 1'b0, 1'b0, 1'b0, 32);

        issue(4'b1001, 32'h12345678, 32'h0, 5'd0); wait_idle();
        $display("SRL sh0 -> %h", last_res);
        check_lit("srl0", 32'h12345678, 1'b0, 1'b0, 1'b0, 1);

        issue(4'b1001, 32'hF0000000, 32'h0, 5'd4); wait_idle();
        $display("SRL F0000000>>4 -> %h", last_res);
        check_lit("srl4", 32'h0F000000, 1'b0, 1'b0, 1'b0, 5);

        issue(4'b1010, 32'hFFFFFFFF, 32'h2, 5'd0); wait_idle();
        $display("MUL FFFFFFFF*2 -> %h ill=%b", last_res, last_ill);
`ifdef ALU_MUL_EN
        check_lit("mul", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33);
        check("mul_hi", {32'd0, hi}, 64'd1);
`else
        check_lit("mul_ill", 32'h0, 1'b1, 1'b0, 1'b1, 1);
`endif

        issue(4'b0011, 32'h1234, 32'h5678, 5'd0); wait_idle();
        $display("OP 0011 -> ill=%b zero=%b", last_ill, last_zero);
        check_lit("ill0011", 32'h0, 1'b1, 1'b0, 1'b1, 1);

        // Back-to-back: each issue lands in the previous op's done cycle.
        issue(4'b0010, 32'd10, 32'd20, 5'd0);
        issue(4'b0110, 32'd3, 32'd10, 5'd0);
        issue(4'b1000, 32'h3, 32'h0, 5'd2);
        while (q.size() != 0 && cyc < q[0].done_cyc) sync();
        issue(4'b0000, 32'hFFFF, 32'h00FF, 5'd0);
        wait_idle();
        $display("back-to-back last -> %h", last_res);
        check_lit("b2b", 32'h000000FF, 1'b0, 1'b0, 1'b0, 1);

        // Reset mid-operation: outputs clear at once, no done follows.
`ifdef ALU_MUL_EN
        issue(4'b1010, 32'h3, 32'h5, 5'd0);
`else
        issue(4'b1000, 32'h3, 32'h0, 5'd20);
`endif
        repeat (4) sync();
        rst_n = 1'b0;
        q.delete();
        #1;
        check_zero_outputs("midrst");
        $display("reset mid-op -> busy=%b result=%h", busy, result);
        sync();
        rst_n = 1'b1;
        repeat (3) sync();

        issue(4'b0010, 32'd100, 32'd23, 5'd0); wait_idle();
        $display("ADD after reset -> %h", last_res);
        check_lit("post_rst", 32'd123, 1'b0, 1'b0, 1'b0, 1);

        repeat (2) sync();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
